// File: rtl/pipelined_floating_point_multiplier.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipelined_floating_point_multiplier: 3-stage IEEE-754-style FP multiply with valid/ready
// Revision: 1.0
// ---------------------------------------------------------------------------
module pipelined_floating_point_multiplier #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  localparam int FLOAT_BIT_WIDTH = EXPONENT_WIDTH + MANTISSA_WIDTH + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FLOAT_BIT_WIDTH-1:0] a,
  input  logic [FLOAT_BIT_WIDTH-1:0] b,
  input  logic [1:0]                 round_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FLOAT_BIT_WIDTH-1:0] out,
  output logic                       underflow_flag,
  output logic                       overflow_flag,
  output logic                       invalid_operation_flag
);

  localparam int E    = EXPONENT_WIDTH;
  localparam int M    = MANTISSA_WIDTH;
  localparam int FBW  = FLOAT_BIT_WIDTH;
  localparam int XW   = E + 2;
  localparam int PW   = 2 * (M + 1);
  localparam int BIAS = 2 ** (E - 1) - 1;
  localparam int EMAX = 2 ** E - 1;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  // Stage registers
  logic                  s1_valid, s2_valid;
  logic                  s1_sign, s2_sign;
  logic signed [XW-1:0]  s1_exp, s2_exp;
  logic [M:0]            s1_sig_a, s1_sig_b;
  logic [PW-1:0]         s2_prod;
  logic                  s1_special, s2_special;
  logic [FBW-1:0]        s1_spec_res, s2_spec_res;
  logic                  s1_inv, s2_inv;
  logic [1:0]            s1_rm, s2_rm;

  logic en1, en2, en3;
  assign en3      = !out_valid || out_ready;
  assign en2      = !s2_valid || en3;
  assign en1      = !s1_valid || en2;
  assign in_ready = en1;

  // Stage 1: unpack and classify
  logic [E-1:0] exp_a, exp_b;
  logic [M-1:0] frac_a, frac_b;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, sign_ab;
  logic signed [XW-1:0] exp_sum;

  assign exp_a   = a[FBW-2:M];
  assign exp_b   = b[FBW-2:M];
  assign frac_a  = a[M-1:0];
  assign frac_b  = b[M-1:0];
  assign a_zero  = (exp_a == '0);
  assign b_zero  = (exp_b == '0);
  assign a_inf   = (&exp_a) && (frac_a == '0);
  assign b_inf   = (&exp_b) && (frac_b == '0);
  assign a_nan   = (&exp_a) && (frac_a != '0);
  assign b_nan   = (&exp_b) && (frac_b != '0);
  assign a_snan  = a_nan && !frac_a[M-1];
  assign b_snan  = b_nan && !frac_b[M-1];
  assign sign_ab = a[FBW-1] ^ b[FBW-1];
  assign exp_sum = {2'b00, exp_a} + {2'b00, exp_b} - XW'(BIAS);

  logic           spec_d;
  logic [FBW-1:0] spec_res_d;
  logic           inv_d;

  always_comb begin
    spec_d     = 1'b1;
    spec_res_d = '0;
    inv_d      = 1'b0;
    if (a_nan) begin
      spec_res_d = {a[FBW-1:M], 1'b1, a[M-2:0]};
      inv_d      = a_snan || b_snan;
    end else if (b_nan) begin
      spec_res_d = {b[FBW-1:M], 1'b1, b[M-2:0]};
      inv_d      = b_snan;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      spec_res_d = {1'b1, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
      inv_d      = 1'b1;
    end else if (a_inf || b_inf) begin
      spec_res_d = {sign_ab, {E{1'b1}}, {M{1'b0}}};
    end else if (a_zero || b_zero) begin
      spec_res_d = {sign_ab, {(FBW-1){1'b0}}};
    end else begin
      spec_d = 1'b0;
    end
  end

  // Stage 3: normalise, round, pack
  logic          hi;
  logic [M-1:0]  mant;
  logic          guard, sticky, inc;
  logic [M:0]    mant_r;
  logic signed [XW-1:0] exp_n;
  logic          ovf, unf, inf_sel;
  logic [FBW-1:0] res_d;
  logic          uf_d, of_d, iv_d;

  always_comb begin
    hi = s2_prod[PW-1];
    if (hi) begin
      mant   = s2_prod[PW-2:M+1];
      guard  = s2_prod[M];
      sticky = |s2_prod[M-1:0];
    end else begin
      mant   = s2_prod[PW-3:M];
      guard  = s2_prod[M-1];
      sticky = |s2_prod[M-2:0];
    end
    case (s2_rm)
      RM_RNE:  inc = guard && (sticky || mant[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = (guard || sticky) && !s2_sign;
      default: inc = (guard || sticky) && s2_sign;
    endcase
    mant_r  = {1'b0, mant} + {{M{1'b0}}, inc};
    exp_n   = s2_exp + {{(XW-1){1'b0}}, hi} + {{(XW-1){1'b0}}, mant_r[M]};
    ovf     = int'(exp_n) >= EMAX;
    unf     = int'(exp_n) <= 0;
    inf_sel = (s2_rm == RM_RNE) || (s2_rm == RM_RUP && !s2_sign) || (s2_rm == RM_RDN && s2_sign);
    uf_d    = 1'b0;
    of_d    = 1'b0;
    iv_d    = 1'b0;
    if (s2_special) begin
      res_d = s2_spec_res;
      iv_d  = s2_inv;
    end else if (ovf) begin
      of_d  = 1'b1;
      res_d = inf_sel ? {s2_sign, {E{1'b1}}, {M{1'b0}}}
                      : {s2_sign, {(E-1){1'b1}}, 1'b0, {M{1'b1}}};
    end else if (unf) begin
      uf_d  = 1'b1;
      res_d = {s2_sign, {(FBW-1){1'b0}}};
    end else begin
      res_d = {s2_sign, exp_n[E-1:0], mant_r[M-1:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid               <= 1'b0;
      s1_sign                <= 1'b0;
      s1_exp                 <= '0;
      s1_sig_a               <= '0;
      s1_sig_b               <= '0;
      s1_special             <= 1'b0;
      s1_spec_res            <= '0;
      s1_inv                 <= 1'b0;
      s1_rm                  <= '0;
      s2_valid               <= 1'b0;
      s2_sign                <= 1'b0;
      s2_exp                 <= '0;
      s2_prod                <= '0;
      s2_special             <= 1'b0;
      s2_spec_res            <= '0;
      s2_inv                 <= 1'b0;
      s2_rm                  <= '0;
      out_valid              <= 1'b0;
      out                    <= '0;
      underflow_flag         <= 1'b0;
      overflow_flag          <= 1'b0;
      invalid_operation_flag <= 1'b0;
    end else begin
      if (en1) begin
        s1_valid    <= in_valid;
        s1_sign     <= sign_ab;
        s1_exp      <= exp_sum;
        s1_sig_a    <= {1'b1, frac_a};
        s1_sig_b    <= {1'b1, frac_b};
        s1_special  <= spec_d;
        s1_spec_res <= spec_res_d;
        s1_inv      <= inv_d;
        s1_rm       <= round_mode;
      end
      if (en2) begin
        s2_valid    <= s1_valid;
        s2_sign     <= s1_sign;
        s2_exp      <= s1_exp;
        s2_prod     <= s1_sig_a * s1_sig_b;
        s2_special  <= s1_special;
        s2_spec_res <= s1_spec_res;
        s2_inv      <= s1_inv;
        s2_rm       <= s1_rm;
      end
      if (en3) begin
        out_valid              <= s2_valid;
        out                    <= res_d;
        underflow_flag         <= uf_d;
        overflow_flag          <= of_d;
        invalid_operation_flag <= iv_d;
      end
    end
  end

endmodule
`default_nettype wire
